// File: rtl/switch_box_config_loader.sv
// switch_box_config_loader: deserialises a LSB-first bitstream of 40-bit frames
// (8-bit tile address + 32-bit config word). A valid frame is broadcast on
// config_data together with a one-cycle one-hot config_en strobe to its tile.
// Address 8'hFF ends the stream. Frames to tiles that do not exist are dropped
// and raise a sticky addr_error.
module switch_box_config_loader #(
  parameter int NUM_TILES  = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [31:0]           config_data,
  output logic [NUM_TILES-1:0]  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_error,
  output logic [7:0]            write_count
);

  typedef enum logic [1:0] {
    SHIFT_ADDR = 2'd0,
    SHIFT_DATA = 2'd1,
    WRITE      = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_NUM_TILES = ADDR_WIDTH'(NUM_TILES);
  localparam logic [5:0]            LP_LAST_ADDR = 6'd7;
  localparam logic [5:0]            LP_LAST_DATA = 6'd39;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data_sr;
  logic [5:0]            r_cnt;
  logic [31:0]           r_config_data;
  logic                  r_addr_error;
  logic [7:0]            r_write_count;

  logic                  w_bit_ready;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [31:0]           w_data_next;
  logic                  w_last_addr_bit;
  logic                  w_last_data_bit;
  logic                  w_end_marker;
  logic                  w_addr_ok;

  // Bits arrive LSB-first, so each new bit enters at the MSB and shifts right;
  // after a full field the first bit has reached bit 0.
  assign w_addr_next     = {bit_in, r_addr[ADDR_WIDTH-1:1]};
  assign w_data_next     = {bit_in, r_data_sr[31:1]};
  assign w_accept        = bit_valid && w_bit_ready;
  assign w_last_addr_bit = (r_state == SHIFT_ADDR) && (r_cnt == LP_LAST_ADDR);
  assign w_last_data_bit = (r_state == SHIFT_DATA) && (r_cnt == LP_LAST_DATA);
  assign w_end_marker    = (w_addr_next == {ADDR_WIDTH{1'b1}});
  // Full-width compare: no aliasing when NUM_TILES is not a power of two.
  assign w_addr_ok       = (r_addr < LP_NUM_TILES);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SHIFT_ADDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake output
  always_comb begin
    w_state_next = r_state;
    w_bit_ready  = 1'b0;
    case (r_state)
      SHIFT_ADDR: begin
        w_bit_ready = 1'b1;
        if (w_accept && w_last_addr_bit) begin
          w_state_next = w_end_marker ? DONE : SHIFT_DATA;
        end
      end
      SHIFT_DATA: begin
        w_bit_ready = 1'b1;
        if (w_accept && w_last_data_bit) begin
          w_state_next = w_addr_ok ? WRITE : SHIFT_ADDR;
        end
      end
      WRITE: begin
        w_state_next = SHIFT_ADDR;
      end
      DONE: begin
        if (start) begin
          w_state_next = SHIFT_ADDR;
        end
      end
      default: begin
        w_state_next = SHIFT_ADDR;
      end
    endcase
  end

  // Frame shift registers and bit counter; the counter returns to 0 at the end
  // of every frame (and on the end marker) so busy reflects a partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_data_sr <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      if (r_state == SHIFT_ADDR) begin
        r_addr <= w_addr_next;
      end else begin
        r_data_sr <= w_data_next;
      end
      if ((w_last_addr_bit && w_end_marker) || w_last_data_bit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  // Config word latch, sticky address error and write counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_config_data <= '0;
      r_addr_error  <= 1'b0;
      r_write_count <= '0;
    end else begin
      if (w_accept && w_last_data_bit) begin
        if (w_addr_ok) begin
          r_config_data <= w_data_next;
        end else begin
          r_addr_error <= 1'b1;
        end
      end
      if (r_state == WRITE) begin
        r_write_count <= r_write_count + 8'd1;
      end
    end
  end

  // Strobe decoded straight from state so an async reset kills it at once;
  // r_addr is frozen during WRITE, which keeps the strobe one-hot.
  generate
    for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_en
      assign config_en[gi] = (r_state == WRITE) && (r_addr == ADDR_WIDTH'(gi));
    end
  endgenerate

  assign bit_ready   = w_bit_ready;
  assign config_data = r_config_data;
  assign busy        = (r_cnt != 6'd0) || (r_state == WRITE);
  assign done        = (r_state == DONE);
  assign addr_error  = r_addr_error;
  assign write_count = r_write_count;

endmodule

// File: doc/switch_box_config_loader.md
Name: switch_box_config_loader

Overview:
- Serial configuration controller for an array of switch_box tiles.
- Deserialises a 1-bit bitstream into (tile address, 32-bit config word) frames.
- Drives the shared config_data bus, plus a one-cycle one-hot config_en strobe to the addressed tile.
- Sits between the off-chip programming interface and the tile array; tracks end-of-stream and address errors.

Parameters:
- NUM_TILES, 16, number of switch_box tiles served (1..255); width of config_en.
- ADDR_WIDTH, 8, frame address field width; fixed at 8. Address 8'hFF is reserved as the end marker.

Ports:
- clk  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  re-arms the loader from DONE; ignored in other states
- bit_in  input  1  serial bitstream data, LSB-first
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  loader accepts a bit this cycle
- config_data  output  32  broadcast config word to all tiles
- config_en  output  NUM_TILES  one-hot write strobe, bit i goes to tile i
- busy  output  1  high when a frame is partially shifted or a WRITE is in progress
- done  output  1  high while in DONE
- addr_error  output  1  sticky flag: a frame addressed a tile >= NUM_TILES (not 8'hFF)
- write_count  output  8  count of successful tile writes, wraps 255->0

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted, all of the following hold:
  - state=SHIFT_ADDR
  - shift register and bit counter=0
  - config_data=0, config_en=0
  - busy=0, done=0, addr_error=0, write_count=0
- Reset mid-frame discards the partial frame. Reset during WRITE suppresses the strobe immediately.
- Frame format: 40 bits, LSB-first. Bits 0-7 = address. Bits 8-39 = config word; the word's bit 0 arrives first.
- A bit transfers on a rising edge where bit_valid && bit_ready.
- bit_ready = 1 in SHIFT_ADDR and SHIFT_DATA, 0 in WRITE and DONE.
- FSM states:
  - SHIFT_ADDR:
    - Collects 8 address bits.
    - After the 8th accepted bit, goes to SHIFT_DATA. The exception is address 8'hFF, which goes to DONE.
  - SHIFT_DATA:
    - Collects 32 data bits.
    - After the 32nd accepted bit: if address < NUM_TILES, go to WRITE and load config_data with the assembled word.
    - Otherwise set addr_error, drop the frame and return to SHIFT_ADDR.
  - WRITE:
    - Exactly one cycle. config_en[addr]=1, all other bits 0. config_data holds the word.
    - write_count increments at the end of the cycle. Next state is SHIFT_ADDR.
  - DONE:
    - done=1, bit_ready=0.
    - start=1 moves to SHIFT_ADDR and clears done. addr_error and write_count persist.
- Latency: the config_en strobe is high in the cycle immediately after the edge that accepts the 40th bit. The tile captures config_data on the edge that ends WRITE.
- config_data holds its last written value between writes. It changes only on entry to WRITE.
- busy=1 when the bit counter != 0 or state=WRITE.
- Gaps (bit_valid=0) at any point stall shifting without losing state. There is no timeout.
- bit_valid=1 during WRITE or DONE is not consumed; the bit must be held by the source.
- The address decode uses the full 8 bits. There is no aliasing when NUM_TILES is not a power of 2.
- config_en is never multi-hot and is 0 outside WRITE.
- addr_error clears only on reset.

Test Plan:
- Single write: reset, stream addr=8'h03, data=32'hDEADBEEF continuously → config_en=16'h0008 for exactly one cycle, the cycle after bit 40; config_data=32'hDEADBEEF; write_count=1; bit_ready=0 only that cycle.
- Back-to-back frames: addr 0 data 32'h1 then addr 15 data 32'h8000_0000 with no gaps → strobes 16'h0001 then 16'h8000; config_data holds 32'h8000_0000 afterwards; write_count=2.
- Bad address and end marker: frame with addr=8'h20 (NUM_TILES=16) → no strobe, addr_error=1, write_count unchanged. Then a valid frame still writes. Then addr 8'hFF → done=1, bit_ready=0. Pulse start → done=0, bit_ready=1.
- Stalls: insert random bit_valid=0 gaps (including a gap between bits 8 and 9) → strobe and data identical to the gap-free run; busy=1 throughout the frame.
- Async reset mid-frame: assert reset after 20 bits, asynchronously off the clock edge → all outputs 0 immediately. After release, a complete frame to addr 5 with data 32'hA5A5A5A5 writes correctly and no stale bits appear.
- Reset during WRITE: assert reset in the strobe cycle → config_en drops to 0 before the next edge; write_count=0.
